// File: rtl/program_loader.sv
// Loads packed instruction words into the CPU's instruction memory from address 0,
// holding the CPU in reset until a halt has been stored.
module program_loader #(
   parameter int ADDR_W = 6
) (
   input  logic              CLK,
   input  logic              Reset,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [5:0]        in_op,
   input  logic [4:0]        in_rs,
   input  logic [4:0]        in_rt,
   input  logic [4:0]        in_rd,
   input  logic [15:0]       in_imm,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              cpu_reset,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W:0]   count
);

   localparam logic [5:0]        OP_HALT = 6'b111111;
   localparam logic [ADDR_W-1:0] LAST    = '1;
   localparam logic [ADDR_W:0]   FULL    = {1'b1, {ADDR_W{1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE, S_ERROR} state_t;

   state_t            r_state, w_next;
   logic [ADDR_W-1:0] r_addr;
   logic [ADDR_W:0]   r_count;
   logic              r_in_ready, r_mem_we, r_cpu_reset, r_busy, r_done, r_err;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [31:0]       r_mem_wdata;

   logic              w_legal, w_accept, w_write, w_clear;
   logic [31:0]       w_word;

   always_comb begin
      w_legal = 1'b1;
      w_word  = '0;
      case (in_op)
         6'b000000, 6'b000010, 6'b010001, 6'b010010:
            w_word = {in_op, in_rs, in_rt, in_rd, 11'b0};
         6'b100000:
            w_word = {in_op, in_rs, 5'b0, in_rd, 11'b0};
         6'b000001, 6'b010000, 6'b100110, 6'b100111, 6'b110000:
            w_word = {in_op, in_rs, in_rt, in_imm};
         OP_HALT:
            w_word = {OP_HALT, 26'b0};
         default:
            w_legal = 1'b0;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (Reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next   = r_state;
      w_clear  = 1'b0;
      w_accept = in_valid && r_in_ready;
      w_write  = w_accept && w_legal;
      case (r_state)
         S_LOAD: begin
            if (w_accept) begin
               if (!w_legal)              w_next = S_ERROR;
               else if (in_op == OP_HALT) w_next = S_DONE;
               else if (r_addr == LAST)   w_next = S_ERROR;  // no slot left for halt
            end
         end
         default: begin
            if (start) begin
               w_next  = S_LOAD;
               w_clear = 1'b1;
            end
         end
      endcase
   end

   // Status outputs are registered from the next state so they line up with the write strobe.
   always_ff @(posedge CLK) begin
      if (Reset) begin
         r_addr      <= '0;
         r_count     <= '0;
         r_in_ready  <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_cpu_reset <= 1'b1;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_mem_we <= w_write;
         if (w_clear) begin
            r_addr  <= '0;
            r_count <= '0;
         end else if (w_write) begin
            r_mem_addr  <= r_addr;
            r_mem_wdata <= w_word;
            if (r_addr != LAST)  r_addr  <= r_addr + 1'b1;
            if (r_count != FULL) r_count <= r_count + 1'b1;
         end
         r_in_ready  <= (w_next == S_LOAD);
         r_busy      <= (w_next == S_LOAD);
         r_cpu_reset <= (w_next != S_DONE);
         r_done      <= (w_next == S_DONE);
         r_err       <= (w_next == S_ERROR);
      end
   end

   assign in_ready  = r_in_ready;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign cpu_reset = r_cpu_reset;
   assign busy      = r_busy;
   assign done      = r_done;
   assign err       = r_err;
   assign count     = r_count;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: a default-width loader and a 4-word loader share stimulus;
// expected writes are queued per instance and matched against each write strobe.
module tb_program_loader;

   logic        clk = 1'b0;
   logic        Reset, start, in_valid;
   logic [5:0]  in_op;
   logic [4:0]  in_rs, in_rt, in_rd;
   logic [15:0] in_imm;

   logic        a_ready, a_we, a_cpu_reset, a_busy, a_done, a_err;
   logic [5:0]  a_addr;
   logic [31:0] a_wdata;
   logic [6:0]  a_count;

   logic        b_ready, b_we, b_cpu_reset, b_busy, b_done, b_err;
   logic [1:0]  b_addr;
   logic [31:0] b_wdata;
   logic [2:0]  b_count;

   int checks = 0;
   int failures = 0;
   logic        mon_a = 1'b1;
   logic        mon_b = 1'b0;
   logic [37:0] qa[$];
   logic [37:0] qb[$];

   always #5 clk = ~clk;

   program_loader #(.ADDR_W(6)) dut_a (
      .CLK(clk), .Reset(Reset), .start(start), .in_valid(in_valid), .in_ready(a_ready),
      .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
      .mem_we(a_we), .mem_addr(a_addr), .mem_wdata(a_wdata), .cpu_reset(a_cpu_reset),
      .busy(a_busy), .done(a_done), .err(a_err), .count(a_count));

   program_loader #(.ADDR_W(2)) dut_b (
      .CLK(clk), .Reset(Reset), .start(start), .in_valid(in_valid), .in_ready(b_ready),
      .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
      .mem_we(b_we), .mem_addr(b_addr), .mem_wdata(b_wdata), .cpu_reset(b_cpu_reset),
      .busy(b_busy), .done(b_done), .err(b_err), .count(b_count));

   // Scoreboard: every strobe must match the oldest expected write.
   always @(negedge clk) begin
      logic [37:0] e;
      if (mon_a && a_we) begin
         checks++;
         if (qa.size() == 0) begin
            failures++;
            $display("FAIL write_a unexpected strobe addr=%0d data=%h", a_addr, a_wdata);
         end else begin
            e = qa.pop_front();
            if ({a_addr, a_wdata} !== e) begin
               failures++;
               $display("FAIL write_a got addr=%0d data=%h expected addr=%0d data=%h",
                        a_addr, a_wdata, e[37:32], e[31:0]);
            end
         end
      end
      if (mon_b && b_we) begin
         checks++;
         if (qb.size() == 0) begin
            failures++;
            $display("FAIL write_b unexpected strobe addr=%0d data=%h", b_addr, b_wdata);
         end else begin
            e = qb.pop_front();
            if ({4'b0, b_addr, b_wdata} !== e) begin
               failures++;
               $display("FAIL write_b got addr=%0d data=%h expected addr=%0d data=%h",
                        b_addr, b_wdata, e[37:32], e[31:0]);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic send(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [15:0] imm);
      in_op = op; in_rs = rs; in_rt = rt; in_rd = rd; in_imm = imm;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic check_drained(input string name);
      checks++;
      if (qa.size() != 0 || qb.size() != 0) begin
         failures++;
         $display("FAIL %s pending writes a=%0d b=%0d expected 0", name, qa.size(), qb.size());
         qa.delete();
         qb.delete();
      end
   endtask

   task automatic test_reset();
      Reset = 1'b1; start = 1'b1;
      tick();
      tick();
      start = 1'b0;
      checks++;
      if ({a_ready, a_we, a_cpu_reset, a_busy, a_done, a_err} !== 6'b001000) begin
         failures++;
         $display("FAIL reset_flags got %b expected 001000",
                  {a_ready, a_we, a_cpu_reset, a_busy, a_done, a_err});
      end
      checks++;
      if (a_addr !== 6'd0 || a_wdata !== 32'd0) begin
         failures++;
         $display("FAIL reset_mem got addr=%0d data=%h expected 0/0", a_addr, a_wdata);
      end
      checks++;
      if (a_count !== 7'd0) begin
         failures++;
         $display("FAIL reset_count got %0d expected 0", a_count);
      end
      Reset = 1'b0;
      tick();
      checks++;
      if (a_ready !== 1'b0 || a_busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_idle got ready=%b busy=%b expected 0/0", a_ready, a_busy);
      end
   endtask

   task automatic test_basic();
      do_reset();
      pulse_start();
      checks++;
      if ({a_ready, a_busy, a_cpu_reset, a_count} !== {3'b111, 7'd0}) begin
         failures++;
         $display("FAIL basic_enter_load got ready=%b busy=%b cpu_reset=%b count=%0d expected 1/1/1/0",
                  a_ready, a_busy, a_cpu_reset, a_count);
      end
      qa.push_back({6'd0, 32'h04010005});
      qa.push_back({6'd1, 32'hFC000000});
      send(6'b000001, 5'd0, 5'd1, 5'd0, 16'h0005);
      send(6'b111111, 5'd3, 5'd3, 5'd3, 16'h1234);
      checks++;
      if ({a_we, a_done, a_cpu_reset, a_ready} !== 4'b1100) begin
         failures++;
         $display("FAIL basic_halt_cycle got we=%b done=%b cpu_reset=%b ready=%b expected 1/1/0/0",
                  a_we, a_done, a_cpu_reset, a_ready);
      end
      tick();
      checks++;
      if (a_count !== 7'd2 || a_we !== 1'b0 || a_done !== 1'b1) begin
         failures++;
         $display("FAIL basic_after got count=%0d we=%b done=%b expected 2/0/1", a_count, a_we, a_done);
      end
      check_drained("basic_drain");
   endtask

   task automatic test_gapped();
      do_reset();
      pulse_start();
      qa.push_back({6'd0, 32'h00221800});
      qa.push_back({6'd1, 32'h80802800});
      qa.push_back({6'd2, 32'hC022FFFE});
      qa.push_back({6'd3, 32'hFC000000});
      send(6'b000000, 5'd1, 5'd2, 5'd3, 16'hAAAA);
      tick();
      send(6'b100000, 5'd4, 5'd7, 5'd5, 16'h5555);
      tick();
      send(6'b110000, 5'd1, 5'd2, 5'd9, 16'hFFFE);
      tick();
      send(6'b111111, 5'd0, 5'd0, 5'd0, 16'h0000);
      tick();
      tick();
      checks++;
      if (a_count !== 7'd4 || a_done !== 1'b1) begin
         failures++;
         $display("FAIL gapped_end got count=%0d done=%b expected 4/1", a_count, a_done);
      end
      check_drained("gapped_drain");
   endtask

   task automatic test_illegal();
      do_reset();
      pulse_start();
      qa.push_back({6'd0, 32'h00221800});
      send(6'b000000, 5'd1, 5'd2, 5'd3, 16'h0);
      send(6'b000011, 5'd1, 5'd2, 5'd3, 16'h0);
      checks++;
      if ({a_err, a_ready, a_we, a_cpu_reset} !== 4'b1001 || a_count !== 7'd1) begin
         failures++;
         $display("FAIL illegal_cycle got err=%b ready=%b we=%b cpu_reset=%b count=%0d expected 1/0/0/1 count=1",
                  a_err, a_ready, a_we, a_cpu_reset, a_count);
      end
      in_op = 6'b000001; in_valid = 1'b1;
      tick(); tick(); tick();
      in_valid = 1'b0;
      checks++;
      if (a_count !== 7'd1 || a_err !== 1'b1) begin
         failures++;
         $display("FAIL illegal_hold got count=%0d err=%b expected 1/1", a_count, a_err);
      end
      check_drained("illegal_drain");
   endtask

   task automatic test_overflow();
      mon_a = 1'b0; mon_b = 1'b1;
      for (int pass = 0; pass < 2; pass++) begin
         do_reset();
         pulse_start();
         for (int k = 0; k < 4; k++) begin
            if (pass == 1 && k == 3) qb.push_back({6'd3, 32'hFC000000});
            else qb.push_back({6'(k), 32'h04010000 | 32'(k)});
         end
         for (int k = 0; k < 4; k++) begin
            if (pass == 1 && k == 3) send(6'b111111, 5'd0, 5'd0, 5'd0, 16'h0);
            else send(6'b000001, 5'd0, 5'd1, 5'd0, 16'(k));
         end
         checks++;
         if ({b_we, b_err, b_done, b_ready} !== ((pass == 0) ? 4'b1100 : 4'b1010)) begin
            failures++;
            $display("FAIL overflow_p%0d got we=%b err=%b done=%b ready=%b", pass, b_we, b_err, b_done, b_ready);
         end
         tick();
         checks++;
         if (b_count !== 3'd4 || b_we !== 1'b0) begin
            failures++;
            $display("FAIL overflow_count_p%0d got count=%0d we=%b expected 4/0", pass, b_count, b_we);
         end
         check_drained("overflow_drain");
      end
      mon_b = 1'b0;
      do_reset();
      qa.delete();
      mon_a = 1'b1;
   endtask

   task automatic test_reset_pending();
      do_reset();
      pulse_start();
      qa.push_back({6'd0, 32'h04010005});
      send(6'b000001, 5'd0, 5'd1, 5'd0, 16'h0005);
      // second instruction would be accepted at the same edge reset is sampled
      in_op = 6'b000010; in_rs = 5'd1; in_rt = 5'd1; in_rd = 5'd1;
      in_valid = 1'b1; Reset = 1'b1;
      tick();
      in_valid = 1'b0; Reset = 1'b0;
      checks++;
      if ({a_ready, a_we, a_cpu_reset, a_busy, a_done, a_err} !== 6'b001000 ||
          a_addr !== 6'd0 || a_wdata !== 32'd0 || a_count !== 7'd0) begin
         failures++;
         $display("FAIL reset_pending got flags=%b addr=%0d data=%h count=%0d expected 001000/0/0/0",
                  {a_ready, a_we, a_cpu_reset, a_busy, a_done, a_err}, a_addr, a_wdata, a_count);
      end
      tick();
      check_drained("reset_pending_drain");
   endtask

   task automatic test_restart();
      do_reset();
      pulse_start();
      qa.push_back({6'd0, 32'h04010005});
      qa.push_back({6'd1, 32'hFC000000});
      send(6'b000001, 5'd0, 5'd1, 5'd0, 16'h0005);
      send(6'b111111, 5'd0, 5'd0, 5'd0, 16'h0);
      tick();
      pulse_start();
      checks++;
      if ({a_done, a_cpu_reset, a_ready, a_err} !== 4'b0110 || a_count !== 7'd0) begin
         failures++;
         $display("FAIL restart_enter got done=%b cpu_reset=%b ready=%b err=%b count=%0d expected 0/1/1/0/0",
                  a_done, a_cpu_reset, a_ready, a_err, a_count);
      end
      qa.push_back({6'd0, 32'h08221800});
      qa.push_back({6'd1, 32'hFC000000});
      send(6'b000010, 5'd1, 5'd2, 5'd3, 16'h0);
      send(6'b111111, 5'd0, 5'd0, 5'd0, 16'h0);
      tick();
      checks++;
      if (a_count !== 7'd2 || a_done !== 1'b1) begin
         failures++;
         $display("FAIL restart_end got count=%0d done=%b expected 2/1", a_count, a_done);
      end
      check_drained("restart_drain");
   endtask

   initial begin
      Reset = 1'b1; start = 1'b0; in_valid = 1'b0;
      in_op = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_imm = '0;
      test_reset();
      test_basic();
      test_gapped();
      test_illegal();
      test_overflow();
      test_reset_pending();
      test_restart();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
